xor_frame_accum: RTL and testbench



---
 rtl/xor_frame_accum_if.sv | 29 ++
 rtl/xor_frame_accum.sv | 104 ++++++++++
 tb/tb_xor_frame_accum.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/xor_frame_accum_if.sv
// Handshake bundle for xor_frame_accum: framed input beats and a per-frame result.
// The master side is the producer/consumer pair and the slave side is the accumulator.
interface xor_frame_accum_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count, out_overflow
  );
endinterface

// File: rtl/xor_frame_accum.sv
// Folds each frame of WIDTH-bit beats into a running XOR and reports the folded word,
// its parity, a saturating beat count and an overflow flag.
module xor_frame_accum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input logic           clk,
  input logic           rst_n,
  xor_frame_accum_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_parity;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_overflow;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_sat;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_ovf_next;

  // in_ready depends only on registered state and reset, never on in_valid
  assign w_in_ready   = (r_state != DONE) && rst_n;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_first      = (r_state == IDLE);
  assign w_sat        = (r_count == CNT_W'(MAX_LEN));
  assign w_acc_next   = w_first ? bus.in_data : (r_acc ^ bus.in_data);
  assign w_count_next = w_first ? CNT_W'(1) : (w_sat ? r_count : r_count + CNT_W'(1));
  assign w_ovf_next   = w_first ? 1'b0 : (r_overflow | w_sat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_parity   <= 1'b0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_overflow <= w_ovf_next;
            if (bus.in_last) begin
              // Result outputs are loaded with the same next-state values as the frame state
              r_state        <= DONE;
              r_out_valid    <= 1'b1;
              r_out_data     <= w_acc_next;
              r_out_parity   <= ^w_acc_next;
              r_out_count    <= w_count_next;
              r_out_overflow <= w_ovf_next;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_parity   <= 1'b0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_parity   = r_out_parity;
  assign bus.out_count    = r_out_count;
  assign bus.out_overflow = r_out_overflow;
endmodule

// File: tb/tb_xor_frame_accum.sv
// Directed bench for xor_frame_accum (WIDTH=8, MAX_LEN=4) with a queue-based scoreboard
// that checks every cycle a result is presented.
module tb_xor_frame_accum;
  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             parity;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;
  exp_t expQ[$];

  xor_frame_accum_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

  xor_frame_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectResult(input logic [WIDTH-1:0] d, input logic p,
                              input logic [CNT_W-1:0] c, input logic o);
    exp_t e;
    e.data   = d;
    e.parity = p;
    e.count  = c;
    e.ovf    = o;
    expQ.push_back(e);
  endtask

  // Drives one beat and returns just after the edge that accepted it
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last);
    bit taken;
    taken        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!taken) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b0 && bus.in_ready === 1'b1) idle = 1'b1;
    end
    if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every presented result, pops on handshake
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("out_data", 32'(bus.out_data), 32'(expQ[0].data));
        checkOutput("out_parity", 32'(bus.out_parity), 32'(expQ[0].parity));
        checkOutput("out_count", 32'(bus.out_count), 32'(expQ[0].count));
        checkOutput("out_overflow", 32'(bus.out_overflow), 32'(expQ[0].ovf));
        if (bus.out_ready === 1'b1) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nChecks       = 0;
    nFails        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for three edges
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("rst_out_parity", 32'(bus.out_parity), 32'd0);
      checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
      checkOutput("rst_out_overflow", 32'(bus.out_overflow), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-beat frame, result one cycle after acceptance
    expectResult(8'hA5, 1'b0, 3'd1, 1'b0);
    applyStimulus(8'hA5, 1'b1);
    @(negedge clk);
    checkOutput("latency_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("done_in_ready", 32'(bus.in_ready), 32'd0);
    waitIdle();

    // Bubbles between beats; in_last on an idle cycle must be ignored
    expectResult(8'h00, 1'b0, 3'd3, 1'b0);
    applyStimulus(8'h0F, 1'b0);
    bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'hF0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 1'b1);
    waitIdle();

    expectResult(8'h07, 1'b1, 3'd2, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h06, 1'b1);
    waitIdle();

    // Back-pressure: result held stable for 5 cycles, offered beats ignored
    expectResult(8'h26, 1'b1, 3'd2, 1'b0);
    applyStimulus(8'h12, 1'b0);
    bus.out_ready = 1'b0;
    applyStimulus(8'h34, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Overflow: six beats into MAX_LEN=4, count saturates, data still folded
    expectResult(8'h00, 1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(8'h01, (i == 5));
    waitIdle();

    expectResult(8'h80, 1'b1, 3'd1, 1'b0);
    applyStimulus(8'h80, 1'b1);
    waitIdle();

    // Reset mid-frame discards the partial frame
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    expectResult(8'h3C, 1'b0, 3'd1, 1'b0);
    applyStimulus(8'h3C, 1'b1);
    waitIdle();

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
